// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI transport.
package sd_pkg;
    typedef enum logic [2:0] {INIT, IDLE, SEND, POLL, RESP, POST} spi_state_t;

    localparam int         SD_CMD_BITS  = 48;
    localparam int         SD_CMD_BYTES = SD_CMD_BITS / 8;
    localparam logic [7:0] SD_FILL_BYTE = 8'hFF;
    localparam int         SD_HALF_W    = 8;
endpackage

// File: rtl/sd_spi_byte_xfer.sv
// One SPI mode-0 byte: half-period divider plus MSB-first shift register, chainable back to back.
// Byte takes 16*half clk; done is combinational on the last clk so the next start has no gap.
module sd_spi_byte_xfer
    import sd_pkg::*;
(
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 start,
    input  logic [7:0]           tx_byte,
    input  logic [SD_HALF_W-1:0] half,
    input  logic                 miso,
    output logic                 done,
    output logic                 rx_vld,
    output logic [7:0]           rx_byte,
    output logic                 sck,
    output logic                 mosi
);
    logic                 active;
    logic [SD_HALF_W-1:0] half_q;
    logic [SD_HALF_W-1:0] cnt;
    logic [3:0]           phase;
    logic [7:0]           tx_sr;
    logic [7:0]           rx_sr;
    logic                 tick;

    assign tick    = active && (cnt == '0);
    assign done    = tick && (phase == 4'd15);
    assign rx_byte = rx_sr;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            active <= 1'b0;
            half_q <= SD_HALF_W'(1);
            cnt    <= '0;
            phase  <= '0;
            tx_sr  <= SD_FILL_BYTE;
            rx_sr  <= SD_FILL_BYTE;
            rx_vld <= 1'b0;
            sck    <= 1'b0;
            mosi   <= 1'b1;
        end else begin
            rx_vld <= 1'b0;
            if (start) begin
                active <= 1'b1;
                half_q <= half;
                cnt    <= half - SD_HALF_W'(1);
                phase  <= '0;
                sck    <= 1'b0;
                mosi   <= tx_byte[7];
                tx_sr  <= {tx_byte[6:0], 1'b1};
            end else if (active) begin
                if (tick) begin
                    cnt   <= half_q - SD_HALF_W'(1);
                    phase <= phase + 4'd1;
                    sck   <= ~sck;
                    if (!sck) begin
                        // rising edge: sample; the 8th one completes rx_byte
                        rx_sr <= {rx_sr[6:0], miso};
                        if (phase == 4'd14)
                            rx_vld <= 1'b1;
                    end else if (phase == 4'd15) begin
                        active <= 1'b0;
                        mosi   <= 1'b1;
                    end else begin
                        mosi  <= tx_sr[7];
                        tx_sr <= {tx_sr[6:0], 1'b1};
                    end
                end else begin
                    cnt <= cnt - SD_HALF_W'(1);
                end
            end
        end
    end
endmodule

// File: rtl/sd_spi_cmd_engine.sv
// SPI-mode SD transport: power-up clock train, 48-bit command frame, NCR poll, response bytes.
// One byte per 16*HALF clk, no inter-byte gap; spi_cmd is dropped (not queued) while spi_busy=1.
module sd_spi_cmd_engine
    import sd_pkg::*;
#(
    parameter int SLOW_HALF = 125,
    parameter int FAST_HALF = 2,
    parameter int INIT_CLKS = 80,
    parameter int NCR_MAX   = 8
) (
    input  logic                   clk,
    input  logic                   res_n,
    input  logic                   sd_speed,
    input  logic [SD_CMD_BITS-1:0] spi_cmd_data,
    input  logic                   spi_cmd,
    input  logic [9:0]             spi_response_len,
    output logic                   spi_busy,
    output logic                   spi_error,
    output logic [7:0]             spi_response,
    output logic                   spi_avail,
    output logic                   sd_sck,
    output logic                   sd_mosi,
    input  logic                   sd_miso,
    output logic                   sd_cs_n
);
    localparam int INIT_BYTES = (INIT_CLKS + 7) / 8;

    spi_state_t             state, state_d;
    logic [7:0]             byte_cnt;
    logic [9:0]             len_q, rem_q;
    logic [SD_CMD_BITS-1:0] frame_q;
    logic [SD_HALF_W-1:0]   half_q;
    logic                   kick_q, init_first, more;
    logic                   xfer_start, xfer_done, xfer_rx_vld;
    logic [7:0]             xfer_rx, tx_byte;

    assign spi_busy   = (state != IDLE);
    assign sd_cs_n    = !(state == SEND || state == POLL || state == RESP);
    assign tx_byte    = (state == SEND) ? frame_q[SD_CMD_BITS-1 -: 8] : SD_FILL_BYTE;
    assign xfer_start = kick_q || more;

    always_comb begin
        state_d = state;
        more    = 1'b0;
        if (xfer_done) begin
            more = 1'b1;
            case (state)
                INIT: if (byte_cnt == 8'(INIT_BYTES - 1)) begin
                    state_d = IDLE;
                    more    = 1'b0;
                end
                SEND: if (byte_cnt == 8'(SD_CMD_BYTES - 1))
                    state_d = (len_q == '0) ? POST : POLL;
                POLL: if (xfer_rx != SD_FILL_BYTE)
                    state_d = (len_q == 10'd1) ? POST : RESP;
                else if (byte_cnt == 8'(NCR_MAX - 1))
                    state_d = POST;
                RESP: if (rem_q == 10'd1)
                    state_d = POST;
                POST: begin
                    state_d = IDLE;
                    more    = 1'b0;
                end
                default: more = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state        <= INIT;
            byte_cnt     <= '0;
            len_q        <= '0;
            rem_q        <= '0;
            frame_q      <= '1;
            half_q       <= SD_HALF_W'(SLOW_HALF);
            kick_q       <= 1'b0;
            init_first   <= 1'b1;
            spi_error    <= 1'b0;
            spi_response <= SD_FILL_BYTE;
            spi_avail    <= 1'b0;
        end else begin
            kick_q    <= 1'b0;
            spi_avail <= 1'b0;
            // SCK rate only follows sd_speed between commands
            if (state == IDLE || init_first)
                half_q <= sd_speed ? SD_HALF_W'(FAST_HALF) : SD_HALF_W'(SLOW_HALF);
            if (init_first) begin
                init_first <= 1'b0;
                kick_q     <= 1'b1;
            end
            if (state == IDLE && spi_cmd) begin
                state     <= SEND;
                frame_q   <= spi_cmd_data;
                len_q     <= spi_response_len;
                spi_error <= 1'b0;
                byte_cnt  <= '0;
                kick_q    <= 1'b1;
            end
            if (xfer_start && state == SEND)
                frame_q <= {frame_q[SD_CMD_BITS-9:0], SD_FILL_BYTE};
            if (xfer_done) begin
                state    <= state_d;
                byte_cnt <= (state_d != state) ? 8'd0 : byte_cnt + 8'd1;
                if (state == POLL && xfer_rx != SD_FILL_BYTE)
                    rem_q <= len_q - 10'd1;
                if (state == RESP)
                    rem_q <= rem_q - 10'd1;
                if (state == POLL && xfer_rx == SD_FILL_BYTE && byte_cnt == 8'(NCR_MAX - 1))
                    spi_error <= 1'b1;
            end
            if (xfer_rx_vld && ((state == POLL && xfer_rx != SD_FILL_BYTE) || state == RESP)) begin
                spi_response <= xfer_rx;
                spi_avail    <= 1'b1;
            end
        end
    end

    sd_spi_byte_xfer u_xfer (
        .clk     (clk),
        .res_n   (res_n),
        .start   (xfer_start),
        .tx_byte (tx_byte),
        .half    (half_q),
        .miso    (sd_miso),
        .done    (xfer_done),
        .rx_vld  (xfer_rx_vld),
        .rx_byte (xfer_rx),
        .sck     (sd_sck),
        .mosi    (sd_mosi)
    );
endmodule
